// File: rtl/airlock_pkg.sv
// Shared airlock definitions: one-hot state encoding, timing defaults and the door/pump drive word.
// Pure declarations; no latency or backpressure of its own.
package airlock_pkg;

    localparam int SECONDS_W      = 4;
    localparam int DEF_EVAC_SECS  = 8;
    localparam int DEF_PRESS_SECS = 5;

    localparam int IDX_PRESS_IDLE = 0;
    localparam int IDX_INNER_OPEN = 1;
    localparam int IDX_EVAC       = 2;
    localparam int IDX_VAC_IDLE   = 3;
    localparam int IDX_OUTER_OPEN = 4;
    localparam int IDX_PRESS      = 5;
    localparam int NUM_STATES     = 6;

    typedef enum logic [NUM_STATES-1:0] {
        PRESS_IDLE = NUM_STATES'(1 << IDX_PRESS_IDLE),
        INNER_OPEN = NUM_STATES'(1 << IDX_INNER_OPEN),
        EVAC       = NUM_STATES'(1 << IDX_EVAC),
        VAC_IDLE   = NUM_STATES'(1 << IDX_VAC_IDLE),
        OUTER_OPEN = NUM_STATES'(1 << IDX_OUTER_OPEN),
        PRESS      = NUM_STATES'(1 << IDX_PRESS)
    } state_t;

    typedef struct packed {
        logic inner_open;
        logic outer_open;
        logic pump_out;
        logic pump_in;
        logic pressurized;
    } drive_t;

    // Doors shut, pumps off, chamber reported at atmosphere.
    localparam drive_t DRIVE_SAFE = '{
        inner_open:  1'b0,
        outer_open:  1'b0,
        pump_out:    1'b0,
        pump_in:     1'b0,
        pressurized: 1'b1
    };

    function automatic drive_t drive_of(input state_t s);
        drive_t d;
        d = DRIVE_SAFE;
        case (s)
            INNER_OPEN: d.inner_open = 1'b1;
            EVAC: begin
                d.pump_out    = 1'b1;
                d.pressurized = 1'b0;
            end
            VAC_IDLE:   d.pressurized = 1'b0;
            OUTER_OPEN: begin
                d.outer_open  = 1'b1;
                d.pressurized = 1'b0;
            end
            PRESS: begin
                d.pump_in     = 1'b1;
                d.pressurized = 1'b0;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/airlock_interlock_ctrl_phase_timer_cmp.sv
// Pump-phase completion detect: masks the first phase cycle (timer still resetting), then seconds >= threshold.
// first is registered on the start edge; done is combinational from seconds; no backpressure.
module phase_timer_cmp
    import airlock_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 active,
    input  logic [SECONDS_W-1:0] seconds,
    input  logic [SECONDS_W-1:0] threshold,
    output logic                 first,
    output logic                 done
);

    always_ff @(posedge clock) begin
        if (reset) begin
            first <= 1'b0;
        end else begin
            first <= start;
        end
    end

    // seconds is stale while first is high, so a saturated count cannot end the phase early.
    assign done = active && !first && (seconds >= threshold);

endmodule

// File: rtl/airlock_interlock_ctrl.sv
// Airlock sequencer: one-hot FSM with registered Moore door/pump drives, 1-clock request-to-output latency.
// No backpressure; requests are levels. Optional abort input under AIRLOCK_ABORT_EN.
module airlock_interlock_ctrl
    import airlock_pkg::*;
#(
    parameter int EVAC_SECS  = DEF_EVAC_SECS,
    parameter int PRESS_SECS = DEF_PRESS_SECS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [SECONDS_W-1:0] seconds,
    input  logic                 req_inner,
    input  logic                 req_outer,
    input  logic                 req_evac,
    input  logic                 req_press,
    input  logic                 req_close,
`ifdef AIRLOCK_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 timer_reset,
    output logic                 inner_open,
    output logic                 outer_open,
    output logic                 pump_out,
    output logic                 pump_in,
    output logic                 pressurized
);

    state_t               state_q;
    state_t               state_d;
    drive_t               drive_q;
    logic                 start;
    logic                 active;
    logic                 done;
    logic                 first;
    logic [SECONDS_W-1:0] threshold;

    assign active    = state_q[IDX_EVAC] || state_q[IDX_PRESS];
    assign threshold = state_q[IDX_PRESS] ? SECONDS_W'(PRESS_SECS) : SECONDS_W'(EVAC_SECS);

    phase_timer_cmp u_phase_cmp (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .active    (active),
        .seconds   (seconds),
        .threshold (threshold),
        .first     (first),
        .done      (done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= PRESS_IDLE;
            drive_q <= DRIVE_SAFE;
        end else begin
            state_q <= state_d;
            drive_q <= drive_of(state_d);
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            PRESS_IDLE: begin
                if (req_inner) begin
                    state_d = INNER_OPEN;
                end else if (req_evac) begin
                    state_d = EVAC;
                    start   = 1'b1;
                end
            end
            INNER_OPEN: begin
                if (req_close) state_d = PRESS_IDLE;
            end
            EVAC: begin
                if (done) state_d = VAC_IDLE;
`ifdef AIRLOCK_ABORT_EN
                // Abort wins over a same-cycle completion: back toward atmosphere.
                if (abort) begin
                    state_d = PRESS;
                    start   = 1'b1;
                end
`endif
            end
            VAC_IDLE: begin
                if (req_outer) begin
                    state_d = OUTER_OPEN;
                end else if (req_press) begin
                    state_d = PRESS;
                    start   = 1'b1;
                end
            end
            OUTER_OPEN: begin
                if (req_close) state_d = VAC_IDLE;
            end
            PRESS: begin
                if (done) state_d = PRESS_IDLE;
            end
            default: state_d = PRESS_IDLE;
        endcase
    end

    assign timer_reset = first;
    assign inner_open  = drive_q.inner_open;
    assign outer_open  = drive_q.outer_open;
    assign pump_out    = drive_q.pump_out;
    assign pump_in     = drive_q.pump_in;
    assign pressurized = drive_q.pressurized;

    // Safety interlocks on the registered drives.
    a_doors_exclusive: assert property (@(posedge clock) !(inner_open && outer_open));
    a_outer_in_vacuum: assert property (@(posedge clock) !(outer_open && pressurized));
    a_inner_at_atm:    assert property (@(posedge clock) !(inner_open && !pressurized));
    a_pumps_exclusive: assert property (@(posedge clock) !(pump_in && pump_out));

endmodule

// File: tb/tb_airlock_interlock_ctrl.sv
// Directed bench for airlock_interlock_ctrl; expected drive words queued at stimulus time, popped after each edge.
module tb_airlock_interlock_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] seconds;
    logic       req_inner, req_outer, req_evac, req_press, req_close;
`ifdef AIRLOCK_ABORT_EN
    logic       abort;
`endif
    logic       timer_reset, inner_open, outer_open, pump_out, pump_in, pressurized;

    always #5 clock = ~clock;

    airlock_interlock_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .seconds     (seconds),
        .req_inner   (req_inner),
        .req_outer   (req_outer),
        .req_evac    (req_evac),
        .req_press   (req_press),
        .req_close   (req_close),
`ifdef AIRLOCK_ABORT_EN
        .abort       (abort),
`endif
        .timer_reset (timer_reset),
        .inner_open  (inner_open),
        .outer_open  (outer_open),
        .pump_out    (pump_out),
        .pump_in     (pump_in),
        .pressurized (pressurized)
    );

    // {timer_reset, inner_open, outer_open, pump_out, pump_in, pressurized}
    localparam logic [5:0] W_IDLE        = 6'b000001;
    localparam logic [5:0] W_INNER       = 6'b010001;
    localparam logic [5:0] W_EVAC_FIRST  = 6'b100100;
    localparam logic [5:0] W_EVAC        = 6'b000100;
    localparam logic [5:0] W_VAC         = 6'b000000;
    localparam logic [5:0] W_OUTER       = 6'b001000;
    localparam logic [5:0] W_PRESS_FIRST = 6'b100010;
    localparam logic [5:0] W_PRESS       = 6'b000010;

    wire [5:0] obs = {timer_reset, inner_open, outer_open, pump_out, pump_in, pressurized};

    typedef struct {
        string      tag;
        logic [5:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic compare_next();
        exp_t x;
        x = sb.pop_front();
        n_checks++;
        assert (obs === x.word) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %b required %b", x.tag, obs, x.word);
        end
    endtask

    // Push the expectation for the inputs just driven, clock once, then score.
    task automatic step_expect(input string tag, input logic [5:0] word);
        exp_t x;
        x.tag  = tag;
        x.word = word;
        sb.push_back(x);
        @(posedge clock);
        #1;
        compare_next();
    endtask

    initial begin
        reset     = 1'b1;
        seconds   = 4'd0;
        req_inner = 1'b0;
        req_outer = 1'b0;
        req_evac  = 1'b0;
        req_press = 1'b0;
        req_close = 1'b0;
`ifdef AIRLOCK_ABORT_EN
        abort     = 1'b0;
`endif
        @(posedge clock);
        #1;
        step_expect("reset_held", W_IDLE);
        reset = 1'b0;
        step_expect("reset_released", W_IDLE);

        // Inner door cycle; evac request ignored while open.
        req_inner = 1'b1;
        step_expect("inner_open", W_INNER);
        req_inner = 1'b0;
        req_evac  = 1'b1;
        step_expect("inner_ignores_evac", W_INNER);
        req_evac  = 1'b0;
        req_close = 1'b1;
        step_expect("inner_close", W_IDLE);
        req_close = 1'b0;

        // Evacuation with stepped seconds; other requests held high must be ignored.
        req_evac = 1'b1;
        step_expect("evac_enter", W_EVAC_FIRST);
        req_evac  = 1'b0;
        req_inner = 1'b1;
        req_outer = 1'b1;
        req_close = 1'b1;
        for (int s = 0; s < 8; s++) begin
            seconds = 4'(s);
            step_expect($sformatf("evac_s%0d", s), W_EVAC);
        end
        req_inner = 1'b0;
        req_outer = 1'b0;
        req_close = 1'b0;
        seconds   = 4'd8;
        step_expect("evac_done", W_VAC);

        // Outer has priority over press in vacuum.
        req_outer = 1'b1;
        req_press = 1'b1;
        step_expect("outer_over_press", W_OUTER);
        req_outer = 1'b0;
        req_press = 1'b0;
        req_close = 1'b1;
        step_expect("outer_close", W_VAC);
        req_close = 1'b0;

        // Pressurize; stale seconds=9 on the masked cycle must not finish the phase.
        seconds   = 4'd9;
        req_press = 1'b1;
        step_expect("press_enter", W_PRESS_FIRST);
        req_press = 1'b0;
        step_expect("press_masked_stale", W_PRESS);
        for (int s = 0; s < 5; s++) begin
            seconds = 4'(s);
            step_expect($sformatf("press_s%0d", s), W_PRESS);
        end
        seconds = 4'd5;
        step_expect("press_done", W_IDLE);

        // Saturated seconds: ignored on the masked cycle, completes on the next.
        seconds  = 4'd15;
        req_evac = 1'b1;
        step_expect("sat_evac_enter", W_EVAC_FIRST);
        req_evac = 1'b0;
        step_expect("sat_evac_masked", W_EVAC);
        step_expect("sat_evac_done", W_VAC);
        req_press = 1'b1;
        step_expect("sat_press_enter", W_PRESS_FIRST);
        req_press = 1'b0;
        step_expect("sat_press_masked", W_PRESS);
        step_expect("sat_press_done", W_IDLE);

        // Reset mid-evacuation aborts the pump on the next edge.
        seconds  = 4'd0;
        req_evac = 1'b1;
        step_expect("rst_evac_enter", W_EVAC_FIRST);
        req_evac = 1'b0;
        seconds  = 4'd2;
        step_expect("rst_evac_run", W_EVAC);
        reset = 1'b1;
        step_expect("rst_mid_evac", W_IDLE);
        reset = 1'b0;
        step_expect("rst_mid_evac_release", W_IDLE);

`ifdef AIRLOCK_ABORT_EN
        seconds  = 4'd0;
        req_evac = 1'b1;
        step_expect("abort_evac_enter", W_EVAC_FIRST);
        req_evac = 1'b0;
        step_expect("abort_evac_masked", W_EVAC);
        for (int s = 1; s < 3; s++) begin
            seconds = 4'(s);
            step_expect($sformatf("abort_evac_s%0d", s), W_EVAC);
        end
        seconds = 4'd3;
        abort   = 1'b1;
        step_expect("abort_to_press", W_PRESS_FIRST);
        seconds = 4'd0;
        step_expect("abort_press_masked", W_PRESS);
        seconds = 4'd2;
        step_expect("abort_ignored_in_press", W_PRESS);
        abort = 1'b0;
        reset = 1'b1;
        step_expect("rst_mid_press", W_IDLE);
        reset = 1'b0;
        step_expect("rst_mid_press_release", W_IDLE);

        // Abort beats a same-cycle completion.
        seconds  = 4'd15;
        req_evac = 1'b1;
        step_expect("prio_evac_enter", W_EVAC_FIRST);
        req_evac = 1'b0;
        step_expect("prio_evac_masked", W_EVAC);
        abort = 1'b1;
        step_expect("prio_abort_over_done", W_PRESS_FIRST);
        abort = 1'b0;
        step_expect("prio_press_masked", W_PRESS);
        step_expect("prio_press_done", W_IDLE);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
